// File: rtl/hazard_ctrl_pkg.sv
// Shared types and opcode constants for the pipeline sequencer.
// Imported by the decoder, interface users and hazard_ctrl.
package pipe_pkg;

  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_IMM    = 5'b00100;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_OP     = 5'b01100;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_e;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2,
    REDIR    = 2'd3
  } hz_state_e;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_en;
    logic memwb_en;
  } ctl_t;

  // MEM (non-load) beats WB; x0 never forwards
  function automatic fwd_sel_e fwd_pick(
    input logic [4:0] rs,
    input logic [4:0] rd_mem,
    input logic       wr_mem,
    input logic       ld_mem,
    input logic [4:0] rd_wb,
    input logic       wr_wb
  );
    fwd_sel_e sel;
    sel = FWD_RF;
    if (rs != 5'd0 && wr_mem && !ld_mem && rd_mem == rs)
      sel = FWD_MEM;
    else if (rs != 5'd0 && wr_wb && rd_wb == rs)
      sel = FWD_WB;
    return sel;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> sequencer signal bundle.
// HAZARD_PERF_EN adds the stall/flush performance counters.
interface hazard_ctrl_if;
  logic [31:0] instr_id_i;
  logic [4:0]  rd_ex_i;
  logic        regwr_ex_i;
  logic        load_ex_i;
  logic [4:0]  rd_mem_i;
  logic        regwr_mem_i;
  logic        load_mem_i;
  logic [4:0]  rd_wb_i;
  logic        regwr_wb_i;
  logic        redirect_ex_i;
  logic        mem_busy_i;
  logic        pc_en_o;
  logic        ifid_en_o;
  logic        ifid_flush_o;
  logic        idex_flush_o;
  logic        exmem_en_o;
  logic        memwb_en_o;
  logic [1:0]  fwd_a_o;
  logic [1:0]  fwd_b_o;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_o;
  logic [31:0] flush_cnt_o;

  modport master (
    output instr_id_i, rd_ex_i, regwr_ex_i,
    output load_ex_i, rd_mem_i, regwr_mem_i,
    output load_mem_i, rd_wb_i, regwr_wb_i,
    output redirect_ex_i, mem_busy_i,
    input  pc_en_o, ifid_en_o, ifid_flush_o,
    input  idex_flush_o, exmem_en_o,
    input  memwb_en_o, fwd_a_o, fwd_b_o,
    input  stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  instr_id_i, rd_ex_i, regwr_ex_i,
    input  load_ex_i, rd_mem_i, regwr_mem_i,
    input  load_mem_i, rd_wb_i, regwr_wb_i,
    input  redirect_ex_i, mem_busy_i,
    output pc_en_o, ifid_en_o, ifid_flush_o,
    output idex_flush_o, exmem_en_o,
    output memwb_en_o, fwd_a_o, fwd_b_o,
    output stall_cnt_o, flush_cnt_o
  );
`else
  modport master (
    output instr_id_i, rd_ex_i, regwr_ex_i,
    output load_ex_i, rd_mem_i, regwr_mem_i,
    output load_mem_i, rd_wb_i, regwr_wb_i,
    output redirect_ex_i, mem_busy_i,
    input  pc_en_o, ifid_en_o, ifid_flush_o,
    input  idex_flush_o, exmem_en_o,
    input  memwb_en_o, fwd_a_o, fwd_b_o
  );

  modport slave (
    input  instr_id_i, rd_ex_i, regwr_ex_i,
    input  load_ex_i, rd_mem_i, regwr_mem_i,
    input  load_mem_i, rd_wb_i, regwr_wb_i,
    input  redirect_ex_i, mem_busy_i,
    output pc_en_o, ifid_en_o, ifid_flush_o,
    output idex_flush_o, exmem_en_o,
    output memwb_en_o, fwd_a_o, fwd_b_o
  );
`endif
endinterface

// File: rtl/hazard_ctrl_src_dec.sv
// Source-register use decoder for the ID instruction.
// Unknown opcodes are treated as reading rs1 only.
module hazard_src_dec
  import pipe_pkg::*;
(
  input  logic [31:0] instr,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic        use_rs1,
  output logic        use_rs2
);

  logic [4:0] op;
  logic       unused_bits;

  assign op  = instr[6:2];
  assign rs1 = instr[19:15];
  assign rs2 = instr[24:20];

  assign unused_bits = ^{instr[31:25],
                         instr[14:7],
                         instr[1:0]};

  // classify register reads by major opcode
  always_comb begin
    use_rs1 = 1'b1;
    use_rs2 = 1'b0;
    unique case (1'b1)
      (op == OP_LUI),
      (op == OP_AUIPC),
      (op == OP_JAL): use_rs1 = 1'b0;
      (op == OP_JALR),
      (op == OP_LOAD),
      (op == OP_IMM): use_rs1 = 1'b1;
      (op == OP_BRANCH),
      (op == OP_STORE),
      (op == OP_OP): use_rs2 = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/hazard_ctrl.sv
// 5-stage pipeline sequencer: stalls, flushes, forwarding.
// Optional HAZARD_PERF_EN adds stall/flush cycle counters.
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int LU_BUBBLES  = 2,
  parameter int REDIR_EXTRA = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  hazard_ctrl_if.slave hz
);

  localparam logic [1:0] LB_INIT =
    2'(LU_BUBBLES - 1);
  localparam logic [1:0] RX_INIT =
    2'(REDIR_EXTRA);

  logic [4:0] rs1;
  logic [4:0] rs2;
  logic       use_rs1;
  logic       use_rs2;
  logic       lu;

  hz_state_e  state;
  hz_state_e  state_n;
  hz_state_e  sv_st;
  hz_state_e  sv_st_n;
  hz_state_e  eff_st;
  logic [1:0] cnt;
  logic [1:0] cnt_n;
  logic [1:0] rcnt;
  logic [1:0] rcnt_n;
  logic [1:0] sv_cnt;
  logic [1:0] sv_cnt_n;
  logic [1:0] sv_rcnt;
  logic [1:0] sv_rcnt_n;
  logic [1:0] eff_cnt;
  logic [1:0] eff_rcnt;
  logic       wake;
  ctl_t       ctl;

  hazard_src_dec u_dec (
    .instr   (hz.instr_id_i),
    .rs1     (rs1),
    .rs2     (rs2),
    .use_rs1 (use_rs1),
    .use_rs2 (use_rs2)
  );

  assign lu = hz.load_ex_i
            & hz.regwr_ex_i
            & (hz.rd_ex_i != 5'd0)
            & ((use_rs1 & (rs1 == hz.rd_ex_i))
             | (use_rs2 & (rs2 == hz.rd_ex_i)));

  assign hz.fwd_a_o = fwd_pick(rs1,
    hz.rd_mem_i, hz.regwr_mem_i, hz.load_mem_i,
    hz.rd_wb_i, hz.regwr_wb_i);
  assign hz.fwd_b_o = fwd_pick(rs2,
    hz.rd_mem_i, hz.regwr_mem_i, hz.load_mem_i,
    hz.rd_wb_i, hz.regwr_wb_i);

  // leaving MEM_WAIT acts as the saved state
  assign wake     = (state == MEM_WAIT)
                  & ~hz.mem_busy_i;
  assign eff_st   = wake ? sv_st   : state;
  assign eff_cnt  = wake ? sv_cnt  : cnt;
  assign eff_rcnt = wake ? sv_rcnt : rcnt;

  // state, counters and freeze snapshot
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= RUN;
      cnt     <= '0;
      rcnt    <= '0;
      sv_st   <= RUN;
      sv_cnt  <= '0;
      sv_rcnt <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      rcnt    <= rcnt_n;
      sv_st   <= sv_st_n;
      sv_cnt  <= sv_cnt_n;
      sv_rcnt <= sv_rcnt_n;
    end
  end

  // next state: busy > redirect > load-use
  always_comb begin
    state_n   = eff_st;
    cnt_n     = eff_cnt;
    rcnt_n    = eff_rcnt;
    sv_st_n   = sv_st;
    sv_cnt_n  = sv_cnt;
    sv_rcnt_n = sv_rcnt;
    if (hz.mem_busy_i) begin
      state_n = MEM_WAIT;
      cnt_n   = cnt;
      rcnt_n  = rcnt;
      if (state != MEM_WAIT) begin
        sv_st_n   = state;
        sv_cnt_n  = cnt;
        sv_rcnt_n = rcnt;
      end
    end else if (hz.redirect_ex_i) begin
      cnt_n   = '0;
      rcnt_n  = RX_INIT;
      state_n = (REDIR_EXTRA == 0) ? RUN : REDIR;
    end else begin
      unique case (eff_st)
        RUN: begin
          if (lu) begin
            cnt_n   = LB_INIT;
            state_n = (LU_BUBBLES > 1)
                    ? LU_STALL : RUN;
          end
        end
        LU_STALL: begin
          cnt_n   = (eff_cnt != 2'd0)
                  ? eff_cnt - 2'd1 : 2'd0;
          state_n = (eff_cnt <= 2'd1)
                  ? RUN : LU_STALL;
        end
        REDIR: begin
          rcnt_n  = (eff_rcnt != 2'd0)
                  ? eff_rcnt - 2'd1 : 2'd0;
          state_n = (eff_rcnt <= 2'd1)
                  ? RUN : REDIR;
        end
        default: state_n = RUN;
      endcase
    end
  end

  // stage enables and flushes
  always_comb begin
    ctl = '{pc_en: 1'b1, ifid_en: 1'b1,
            ifid_flush: 1'b0, idex_flush: 1'b0,
            exmem_en: 1'b1, memwb_en: 1'b1};
    if (hz.mem_busy_i) begin
      ctl = '0;
    end else if (hz.redirect_ex_i) begin
      ctl.ifid_flush = 1'b1;
      ctl.idex_flush = 1'b1;
    end else begin
      unique case (eff_st)
        RUN: begin
          if (lu) begin
            ctl.pc_en      = 1'b0;
            ctl.ifid_en    = 1'b0;
            ctl.idex_flush = 1'b1;
          end
        end
        LU_STALL: begin
          ctl.pc_en      = 1'b0;
          ctl.ifid_en    = 1'b0;
          ctl.idex_flush = 1'b1;
        end
        REDIR: begin
          ctl.ifid_flush = (eff_rcnt != 2'd0);
        end
        default: ;
      endcase
    end
  end

  assign hz.pc_en_o      = ctl.pc_en;
  assign hz.ifid_en_o    = ctl.ifid_en;
  assign hz.ifid_flush_o = ctl.ifid_flush;
  assign hz.idex_flush_o = ctl.idex_flush;
  assign hz.exmem_en_o   = ctl.exmem_en;
  assign hz.memwb_en_o   = ctl.memwb_en;

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  // count stalled-PC and IF/ID-flush cycles
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!ctl.pc_en)
        stall_cnt <= stall_cnt + 32'd1;
      if (ctl.ifid_flush)
        flush_cnt <= flush_cnt + 32'd1;
    end
  end

  assign hz.stall_cnt_o = stall_cnt;
  assign hz.flush_cnt_o = flush_cnt;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized bench for hazard_ctrl with a bubble/flush
// budget model plus directed scenario checks.
module tb_hazard_ctrl;

  localparam int LUB = 2;
  localparam int RXE = 1;

  localparam logic [4:0] T_LUI = 5'b01101;
  localparam logic [4:0] T_AUI = 5'b00101;
  localparam logic [4:0] T_JAL = 5'b11011;
  localparam logic [4:0] T_JLR = 5'b11001;
  localparam logic [4:0] T_LD  = 5'b00000;
  localparam logic [4:0] T_IMM = 5'b00100;
  localparam logic [4:0] T_BR  = 5'b11000;
  localparam logic [4:0] T_ST  = 5'b01000;
  localparam logic [4:0] T_OP  = 5'b01100;
  localparam logic [4:0] T_SYS = 5'b11100;

  // pc, ifid_en, ifid_fl, idex_fl, exmem, memwb
  localparam logic [5:0] IDLE = 6'b110011;
  localparam logic [5:0] STAL = 6'b000111;
  localparam logic [5:0] RDR  = 6'b111111;
  localparam logic [5:0] RXT  = 6'b111011;
  localparam logic [5:0] FRZ  = 6'b000000;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   pb = 0;
  int   pf = 0;
  int   m_stall = 0;
  int   m_flush = 0;

  hazard_ctrl_if hz ();

  hazard_ctrl #(
    .LU_BUBBLES  (LUB),
    .REDIR_EXTRA (RXE)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .hz    (hz)
  );

  always #5 clk = ~clk;

  logic [5:0] got_ctl;
  logic [3:0] got_fwd;
  assign got_ctl = {hz.pc_en_o, hz.ifid_en_o,
                    hz.ifid_flush_o, hz.idex_flush_o,
                    hz.exmem_en_o, hz.memwb_en_o};
  assign got_fwd = {hz.fwd_a_o, hz.fwd_b_o};

  function automatic void chk(
    input string nm,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h at %0t",
               nm, got, exp, $time);
    end
  endfunction

  function automatic logic [31:0] mk(
    input logic [4:0] op,
    input logic [4:0] r1,
    input logic [4:0] r2
  );
    return {7'd0, r2, r1, 3'd0, 5'd7, op, 2'b11};
  endfunction

  function automatic logic [1:0] m_fwd(
    input logic [4:0] rs
  );
    if (rs != 0 && hz.regwr_mem_i &&
        !hz.load_mem_i && hz.rd_mem_i == rs)
      return 2'b01;
    if (rs != 0 && hz.regwr_wb_i &&
        hz.rd_wb_i == rs)
      return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic m_haz();
    logic [4:0] op;
    logic [4:0] r1;
    logic [4:0] r2;
    logic u1;
    logic u2;
    op = hz.instr_id_i[6:2];
    r1 = hz.instr_id_i[19:15];
    r2 = hz.instr_id_i[24:20];
    u1 = !(op == T_LUI || op == T_AUI ||
           op == T_JAL);
    u2 = (op == T_BR || op == T_ST || op == T_OP);
    return hz.load_ex_i && hz.regwr_ex_i &&
           hz.rd_ex_i != 0 &&
           ((u1 && r1 == hz.rd_ex_i) ||
            (u2 && r2 == hz.rd_ex_i));
  endfunction

  // reference: pending flush / bubble budgets,
  // frozen untouched while memory is busy
  always @(negedge clk) begin
    logic [5:0] ec;
    logic hzd;
    chk("fwd", 32'(got_fwd),
        32'({m_fwd(hz.instr_id_i[19:15]),
             m_fwd(hz.instr_id_i[24:20])}));
    if (rst) begin
      pb = 0;
      pf = 0;
      m_stall = 0;
      m_flush = 0;
    end else begin
`ifdef HAZARD_PERF_EN
      chk("stall_cnt", hz.stall_cnt_o, m_stall);
      chk("flush_cnt", hz.flush_cnt_o, m_flush);
`endif
      hzd = m_haz();
      if (hz.mem_busy_i) begin
        ec = FRZ;
      end else if (hz.redirect_ex_i) begin
        ec = RDR;
        pb = 0;
        pf = RXE;
      end else if (pf > 0) begin
        ec = RXT;
        pf--;
      end else if (pb > 0) begin
        ec = STAL;
        pb--;
      end else if (hzd) begin
        ec = STAL;
        pb = LUB - 1;
      end else begin
        ec = IDLE;
      end
      chk("ctl", 32'(got_ctl), 32'(ec));
      if (!ec[5]) m_stall++;
      if (ec[3]) m_flush++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    hz.instr_id_i    = 32'h0000_0013;
    hz.rd_ex_i       = 5'd0;
    hz.regwr_ex_i    = 1'b0;
    hz.load_ex_i     = 1'b0;
    hz.rd_mem_i      = 5'd0;
    hz.regwr_mem_i   = 1'b0;
    hz.load_mem_i    = 1'b0;
    hz.rd_wb_i       = 5'd0;
    hz.regwr_wb_i    = 1'b0;
    hz.redirect_ex_i = 1'b0;
    hz.mem_busy_i    = 1'b0;
  endtask

  task automatic lu_x5();
    hz.instr_id_i = mk(T_OP, 5'd5, 5'd1);
    hz.rd_ex_i    = 5'd5;
    hz.regwr_ex_i = 1'b1;
    hz.load_ex_i  = 1'b1;
  endtask

  task automatic rnd();
    logic [4:0] ops [10];
    logic [31:0] w;
    ops = '{T_LUI, T_AUI, T_JAL, T_JLR, T_LD,
            T_IMM, T_BR, T_ST, T_OP, T_SYS};
    w = $urandom;
    w[1:0]   = 2'b11;
    w[6:2]   = ops[$urandom_range(0, 9)];
    w[19:15] = 5'($urandom_range(0, 7));
    w[24:20] = 5'($urandom_range(0, 7));
    hz.instr_id_i    = w;
    hz.rd_ex_i       = 5'($urandom_range(0, 7));
    hz.regwr_ex_i    = ($urandom_range(0, 3) != 0);
    hz.load_ex_i     = ($urandom_range(0, 9) < 4);
    hz.rd_mem_i      = 5'($urandom_range(0, 7));
    hz.regwr_mem_i   = ($urandom_range(0, 3) != 0);
    hz.load_mem_i    = ($urandom_range(0, 9) < 3);
    hz.rd_wb_i       = 5'($urandom_range(0, 7));
    hz.regwr_wb_i    = ($urandom_range(0, 3) != 0);
    hz.redirect_ex_i = ($urandom_range(0, 99) < 8);
    hz.mem_busy_i    = ($urandom_range(0, 99) < 15);
    rst              = ($urandom_range(0, 99) < 2);
  endtask

  initial begin
    set_idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_idle", 32'(got_ctl), 32'(IDLE));
    tick();

    // load-use: two bubbles, then WB forward
    lu_x5();
    @(negedge clk);
    chk("lu_b1", 32'(got_ctl), 32'(STAL));
    tick();
    hz.rd_ex_i     = 5'd0;
    hz.regwr_ex_i  = 1'b0;
    hz.load_ex_i   = 1'b0;
    hz.rd_mem_i    = 5'd5;
    hz.regwr_mem_i = 1'b1;
    hz.load_mem_i  = 1'b1;
    @(negedge clk);
    chk("lu_b2", 32'(got_ctl), 32'(STAL));
    chk("lu_mem_noload", 32'(hz.fwd_a_o), 32'd0);
    tick();
    hz.rd_mem_i    = 5'd0;
    hz.regwr_mem_i = 1'b0;
    hz.load_mem_i  = 1'b0;
    hz.rd_wb_i     = 5'd5;
    hz.regwr_wb_i  = 1'b1;
    @(negedge clk);
    chk("lu_rel", 32'(got_ctl), 32'(IDLE));
    chk("lu_fwd_wb", 32'(hz.fwd_a_o), 32'd2);
    tick();

    // MEM forward, x0 never forwards
    set_idle();
    hz.instr_id_i  = mk(T_OP, 5'd3, 5'd3);
    hz.rd_mem_i    = 5'd3;
    hz.regwr_mem_i = 1'b1;
    hz.rd_wb_i     = 5'd3;
    hz.regwr_wb_i  = 1'b1;
    @(negedge clk);
    chk("fwd_mem", 32'(got_fwd), 32'h5);
    chk("fwd_nostall", 32'(got_ctl), 32'(IDLE));
    tick();
    hz.instr_id_i = mk(T_OP, 5'd0, 5'd0);
    hz.rd_mem_i   = 5'd0;
    hz.rd_wb_i    = 5'd0;
    @(negedge clk);
    chk("fwd_x0", 32'(got_fwd), 32'h0);
    tick();

    // redirect pulse
    set_idle();
    hz.redirect_ex_i = 1'b1;
    @(negedge clk);
    chk("redir_0", 32'(got_ctl), 32'(RDR));
    tick();
    hz.redirect_ex_i = 1'b0;
    @(negedge clk);
    chk("redir_1", 32'(got_ctl), 32'(RXT));
    tick();
    @(negedge clk);
    chk("redir_2", 32'(got_ctl), 32'(IDLE));
    tick();

    // freeze in LU_STALL with one bubble left
    lu_x5();
    @(negedge clk);
    chk("fz_lu", 32'(got_ctl), 32'(STAL));
    tick();
    set_idle();
    hz.mem_busy_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("fz_hold", 32'(got_ctl), 32'(FRZ));
      tick();
    end
    hz.mem_busy_i = 1'b0;
    @(negedge clk);
    chk("fz_bubble", 32'(got_ctl), 32'(STAL));
    tick();
    @(negedge clk);
    chk("fz_run", 32'(got_ctl), 32'(IDLE));
    tick();

    // reset in REDIR with a frozen flush pending
    hz.redirect_ex_i = 1'b1;
    tick();
    hz.redirect_ex_i = 1'b0;
    hz.mem_busy_i    = 1'b1;
    rst              = 1'b1;
    tick();
    hz.mem_busy_i = 1'b0;
    rst           = 1'b0;
    @(negedge clk);
    chk("rst_redir", 32'(got_ctl), 32'(IDLE));
    tick();

    // lui has no source, no stall
    hz.instr_id_i = {15'h0, 5'd5, 5'd5, T_LUI, 2'b11};
    hz.rd_ex_i    = 5'd5;
    hz.regwr_ex_i = 1'b1;
    hz.load_ex_i  = 1'b1;
    @(negedge clk);
    chk("lui_nostall", 32'(got_ctl), 32'(IDLE));
    tick();

    for (int i = 0; i < 3000; i++) begin
      rnd();
      tick();
    end

    set_idle();
    rst = 1'b0;
    tick();
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
